// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: program counter plus the IF/ID pipeline register,
// with load-use stall, redirect/flush and a sticky misaligned-target fault.
module fetch_pc_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] NOP_WORD     = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] PCAddResult,
    input  logic [WIDTH-1:0] Instruction,
    input  logic             Stall,
    input  logic             Redirect,
    input  logic [WIDTH-1:0] RedirectTarget,
    output logic [WIDTH-1:0] PCResult,
    output logic [WIDTH-1:0] IF_ID_Instruction,
    output logic [WIDTH-1:0] IF_ID_PCPlus4,
    output logic             IF_ID_Valid,
    output logic             MisalignedFault,
    output logic [1:0]       FetchState
);

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        FAULT = 2'b10
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pc_nxt;
    logic [WIDTH-1:0] inst_nxt;
    logic [WIDTH-1:0] pc4_nxt;
    logic             valid_nxt;
    logic             fault_nxt;

    function automatic logic word_aligned(input logic [WIDTH-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

    assign FetchState = state;

    always_comb begin
        state_nxt = state;
        pc_nxt    = PCResult;
        inst_nxt  = IF_ID_Instruction;
        pc4_nxt   = IF_ID_PCPlus4;
        valid_nxt = IF_ID_Valid;
        fault_nxt = MisalignedFault;
        case (state)
            BOOT: begin
                inst_nxt  = NOP_WORD;
                pc4_nxt   = '0;
                valid_nxt = 1'b0;
                state_nxt = RUN;
            end
            RUN: begin
                if (Redirect) begin
                    // Either way the wrong-path fetch sitting in IF is flushed.
                    inst_nxt  = NOP_WORD;
                    pc4_nxt   = '0;
                    valid_nxt = 1'b0;
                    if (word_aligned(RedirectTarget)) begin
                        pc_nxt = RedirectTarget;
                    end else begin
                        fault_nxt = 1'b1;
                        state_nxt = FAULT;
                    end
                end else if (!Stall) begin
                    pc_nxt    = PCAddResult;
                    inst_nxt  = Instruction;
                    pc4_nxt   = PCAddResult;
                    valid_nxt = 1'b1;
                end
            end
            default: begin
                // FAULT (and the unused encoding) only feeds bubbles until reset.
                inst_nxt  = NOP_WORD;
                pc4_nxt   = '0;
                valid_nxt = 1'b0;
                state_nxt = FAULT;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state             <= BOOT;
            PCResult          <= RESET_VECTOR;
            IF_ID_Instruction <= NOP_WORD;
            IF_ID_PCPlus4     <= '0;
            IF_ID_Valid       <= 1'b0;
            MisalignedFault   <= 1'b0;
        end else begin
            state             <= state_nxt;
            PCResult          <= pc_nxt;
            IF_ID_Instruction <= inst_nxt;
            IF_ID_PCPlus4     <= pc4_nxt;
            IF_ID_Valid       <= valid_nxt;
            MisalignedFault   <= fault_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus a randomized run checked
// against a behavioural model of the fetch stage.
module tb_fetch_pc_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] PCAddResult;
    logic [31:0] Instruction;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic [31:0] PCResult;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic        MisalignedFault;
    logic [1:0]  FetchState;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_inst, m_pc4;
    logic        m_valid, m_fault;
    int          m_mode;   // 0 booting, 1 running, 2 faulted

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // External PC+4 adder and instruction memory
    assign PCAddResult = PCResult + 32'd4;
    assign Instruction = mem_word(PCResult);

    wire [99:0] obs = {PCResult, IF_ID_Instruction, IF_ID_PCPlus4,
                       IF_ID_Valid, MisalignedFault, FetchState};
    wire [99:0] mdl = {m_pc, m_inst, m_pc4, m_valid, m_fault, 2'(m_mode)};

    fetch_pc_unit dut (
        .Clk(Clk), .Reset(Reset), .PCAddResult(PCAddResult),
        .Instruction(Instruction), .Stall(Stall), .Redirect(Redirect),
        .RedirectTarget(RedirectTarget), .PCResult(PCResult),
        .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PCPlus4(IF_ID_PCPlus4),
        .IF_ID_Valid(IF_ID_Valid), .MisalignedFault(MisalignedFault),
        .FetchState(FetchState)
    );

    task automatic model_step();
        if (Reset) begin
            m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0;
            m_valid = 0; m_fault = 0; m_mode = 0;
        end else if (m_mode == 0) begin
            m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 0; m_mode = 1;
        end else if (m_mode == 2) begin
            m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 0;
        end else if (Redirect) begin
            m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 0;
            if (RedirectTarget % 4 == 0) m_pc = RedirectTarget;
            else begin m_fault = 1; m_mode = 2; end
        end else if (!Stall) begin
            m_inst  = mem_word(m_pc);
            m_pc    = m_pc + 4;
            m_pc4   = m_pc;
            m_valid = 1;
        end
    endtask

    // Advance one clock: model sees the pre-edge inputs; outputs settle 1 unit after the edge.
    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        logic [99:0] exp;
        Reset = 1; Stall = 0; Redirect = 0; RedirectTarget = 0;
        tick(); tick();
        exp = {32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL reset_values actual=%h required=%h", obs, exp);
        end
        Reset = 0;
        tick();
        exp = {32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b01};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL boot_edge actual=%h required=%h", obs, exp);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            exp = {32'(4*k), mem_word(32'(4*k-4)), 32'(4*k), 1'b1, 1'b0, 2'b01};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL advance_%0d actual=%h required=%h", k, obs, exp);
            end
        end
    endtask

    task automatic test_stall();
        logic [99:0] exp;
        Reset = 1; tick(); Reset = 0;
        tick(); tick(); tick();   // BOOT, PC=4, PC=8
        Stall = 1;
        exp = {32'h8, mem_word(32'h4), 32'h8, 1'b1, 1'b0, 2'b01};
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL stall_hold_%0d actual=%h required=%h", k, obs, exp);
            end
        end
        Stall = 0;
        tick();
        exp = {32'hC, mem_word(32'h8), 32'hC, 1'b1, 1'b0, 2'b01};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL stall_release actual=%h required=%h", obs, exp);
        end
    endtask

    task automatic test_redirect_stall();
        logic [99:0] exp;
        Redirect = 1; RedirectTarget = 32'h40; Stall = 1;
        tick();
        exp = {32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 2'b01};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL redirect_flush actual=%h required=%h", obs, exp);
        end
        Redirect = 0; Stall = 0;
        tick();
        exp = {32'h44, mem_word(32'h40), 32'h44, 1'b1, 1'b0, 2'b01};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL redirect_first_valid actual=%h required=%h", obs, exp);
        end
    endtask

    task automatic test_misaligned();
        logic [99:0] exp;
        Redirect = 1; RedirectTarget = 32'h42;
        tick();
        exp = {32'h44, 32'h0, 32'h0, 1'b0, 1'b1, 2'b10};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL misaligned_enter actual=%h required=%h", obs, exp);
        end
        RedirectTarget = 32'h80;
        for (int k = 0; k < 5; k++) begin
            Stall = 1'($urandom_range(0, 1));
            Redirect = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL fault_sticky_%0d actual=%h required=%h", k, obs, exp);
            end
        end
        Reset = 1; Redirect = 0; Stall = 0;
        tick();
        exp = {32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL fault_reset actual=%h required=%h", obs, exp);
        end
        Reset = 0;
    endtask

    task automatic test_wrap();
        logic [99:0] exp;
        tick();   // BOOT edge
        Redirect = 1; RedirectTarget = 32'hFFFF_FFFC;
        tick();
        exp = {32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, 2'b01};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL wrap_redirect actual=%h required=%h", obs, exp);
        end
        Redirect = 0;
        tick();
        exp = {32'h0, mem_word(32'hFFFF_FFFC), 32'h0, 1'b1, 1'b0, 2'b01};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL wrap_advance actual=%h required=%h", obs, exp);
        end
    endtask

    task automatic test_reset_mid_stall();
        logic [99:0] exp;
        Redirect = 1; RedirectTarget = 32'h20;
        tick();
        Redirect = 0; Stall = 1;
        tick();
        exp = {32'h20, 32'h0, 32'h0, 1'b0, 1'b0, 2'b01};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL stall_at_20 actual=%h required=%h", obs, exp);
        end
        Reset = 1;
        tick();
        exp = {32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL reset_mid_stall actual=%h required=%h", obs, exp);
        end
        Reset = 0; Stall = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            Reset    = ($urandom_range(0, 39) == 0);
            Stall    = ($urandom_range(0, 3) == 0);
            Redirect = ($urandom_range(0, 5) == 0);
            RedirectTarget = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0)
                RedirectTarget = RedirectTarget | 32'($urandom_range(1, 3));
            tick();
            checks++;
            if (obs !== mdl) begin
                failures++;
                $display("FAIL random_cycle_%0d actual=%h required=%h", i, obs, mdl);
            end
        end
        Reset = 0; Stall = 0; Redirect = 0;
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect_stall();
        test_misaligned();
        test_wrap();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
